// File: rtl/rgb_pwm_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pwm_pkg : register map and default widths for the RGB PWM controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rgb_pwm_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_PRESC_W = 16;
    localparam int DEF_FADE_W  = 8;

    localparam logic [4:0] ADDR_CTRL      = 5'h00;
    localparam logic [4:0] ADDR_PRESCALE  = 5'h04;
    localparam logic [4:0] ADDR_TARGET_R  = 5'h08;
    localparam logic [4:0] ADDR_TARGET_G  = 5'h0C;
    localparam logic [4:0] ADDR_TARGET_B  = 5'h10;
    localparam logic [4:0] ADDR_FADE_RATE = 5'h14;
    localparam logic [4:0] ADDR_STATUS    = 5'h18;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FADE_EN = 1;

endpackage

`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
// ---------------------------------------------------------------------------
// rgb_pwm_channel : applied-duty register, boundary/fade update and compare
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] target,
    input  logic             boundary,
    input  logic             fade_step,
    input  logic             fade_en,
    input  logic             en,
    output logic             pwm,
    output logic             busy
);

    logic [CNT_W-1:0] applied;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            applied <= '0;
            pwm     <= 1'b0;
        end else begin
            pwm <= en & (cnt < applied);
            if (!en) begin
                applied <= target;
            end else if (boundary) begin
                if (!fade_en) begin
                    applied <= target;
                end else if (fade_step) begin
                    if (applied < target)
                        applied <= applied + 1'b1;
                    else if (applied > target)
                        applied <= applied - 1'b1;
                end
            end
        end
    end

    assign busy = (applied != target);

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// rgb_pwm_ctrl : APB-slave PWM controller driving the three RGB LED inputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W,
    parameter int FADE_W  = DEF_FADE_W
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [2:0]  pwm_out,
    output logic        fade_busy
);

    logic [1:0]              ctrl;
    logic [PRESC_W-1:0]      prescale;
    logic [PRESC_W-1:0]      psc;
    logic [2:0][CNT_W-1:0]   target;
    logic [FADE_W-1:0]       fade_rate;
    logic [FADE_W-1:0]       fade_cnt;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              busy;
    logic [4:0]              addr;
    logic                    wr;
    logic                    en;
    logic                    fade_en;
    logic                    tick;
    logic                    boundary;
    logic                    fade_step;
    logic                    unused_apb;

    assign addr       = {PADDR[4:2], 2'b00};
    assign wr         = PSEL & PENABLE & PWRITE;
    assign en         = ctrl[CTRL_EN];
    assign fade_en    = ctrl[CTRL_FADE_EN];
    assign PREADY     = 1'b1;
    assign PSLVERR    = 1'b0;
    assign unused_apb = ^{PWDATA, PADDR[1:0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl      <= '0;
            prescale  <= '0;
            target    <= '0;
            fade_rate <= '0;
        end else if (wr) begin
            case (addr)
                ADDR_CTRL:      ctrl      <= PWDATA[1:0];
                ADDR_PRESCALE:  prescale  <= PWDATA[PRESC_W-1:0];
                ADDR_TARGET_R:  target[0] <= PWDATA[CNT_W-1:0];
                ADDR_TARGET_G:  target[1] <= PWDATA[CNT_W-1:0];
                ADDR_TARGET_B:  target[2] <= PWDATA[CNT_W-1:0];
                ADDR_FADE_RATE: fade_rate <= PWDATA[FADE_W-1:0];
                default: ;
            endcase
        end
    end

    // >= compare lets a lowered PRESCALE fire immediately instead of wrapping psc
    assign tick      = en & (psc >= prescale);
    assign boundary  = tick & (cnt == {CNT_W{1'b1}});
    assign fade_step = boundary & (fade_cnt >= fade_rate);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            psc       <= '0;
            cnt       <= '0;
            fade_cnt  <= '0;
            fade_busy <= 1'b0;
        end else begin
            fade_busy <= |busy;
            if (!en) begin
                psc      <= '0;
                cnt      <= '0;
                fade_cnt <= '0;
            end else begin
                psc <= tick ? '0 : psc + 1'b1;
                if (tick)
                    cnt <= cnt + 1'b1;
                if (boundary) begin
                    if (!fade_en || fade_step)
                        fade_cnt <= '0;
                    else
                        fade_cnt <= fade_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        rgb_pwm_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (HCLK),
            .rst_n     (HRESETn),
            .cnt       (cnt),
            .target    (target[i]),
            .boundary  (boundary),
            .fade_step (fade_step),
            .fade_en   (fade_en),
            .en        (en),
            .pwm       (pwm_out[i]),
            .busy      (busy[i])
        );
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (addr)
                ADDR_CTRL:      PRDATA = 32'(ctrl);
                ADDR_PRESCALE:  PRDATA = 32'(prescale);
                ADDR_TARGET_R:  PRDATA = 32'(target[0]);
                ADDR_TARGET_G:  PRDATA = 32'(target[1]);
                ADDR_TARGET_B:  PRDATA = 32'(target[2]);
                ADDR_FADE_RATE: PRDATA = 32'(fade_rate);
                ADDR_STATUS:    PRDATA = 32'(cnt) | (32'(fade_busy) << 8);
                default:        PRDATA = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_ctrl : directed self-checking bench for rgb_pwm_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rgb_pwm_ctrl;

    logic        HCLK;
    logic        HRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [2:0]  pwm_out;
    logic        fade_busy;

    int total = 0;
    int bad   = 0;

    rgb_pwm_ctrl dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .pwm_out   (pwm_out),
        .fade_busy (fade_busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge HCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge HCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int hr, hg, hb, hg2;
        int per [9];

        HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;

        // reset defaults
        #1;
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_busy", 32'(fade_busy), 0);
        check("rst_prdata", PRDATA, 0);
        apb_read(5'h00, rd); check("rst_ctrl", rd, 0);
        apb_read(5'h04, rd); check("rst_presc", rd, 0);
        apb_read(5'h18, rd); check("rst_status", rd, 0);
        @(negedge HCLK); HRESETn = 1'b1;

        // basic duty: R=64, G=0, B=255, one tick per cycle
        apb_write(5'h04, 0);
        apb_write(5'h08, 64);
        apb_write(5'h0C, 0);
        apb_write(5'h10, 255);
        apb_write(5'h00, 1);
        hr = 0; hg = 0; hb = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge HCLK);
            hr += int'(pwm_out[0]); hg += int'(pwm_out[1]); hb += int'(pwm_out[2]);
        end
        check("duty_r64", 32'(hr), 64);
        check("duty_g0", 32'(hg), 0);
        check("duty_b255", 32'(hb), 255);

        // glitch-free target update written at cnt=100
        apb_write(5'h00, 0);
        apb_write(5'h0C, 50);
        apb_write(5'h00, 1);
        hg = 0; hg2 = 0;
        for (int k = 1; k <= 512; k++) begin
            @(negedge HCLK);
            if (k <= 256) hg += int'(pwm_out[1]);
            else          hg2 += int'(pwm_out[1]);
            if (k == 99) begin
                PSEL = 1'b1; PWRITE = 1'b1; PADDR = 5'h0C; PWDATA = 200; PENABLE = 1'b0;
            end
            if (k == 100) PENABLE = 1'b1;
            if (k == 101) begin PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; end
        end
        check("glitch_old_period", 32'(hg), 50);
        check("glitch_new_period", 32'(hg2), 200);

        // prescaler 3 -> 1024-cycle period, then drop to 0 while psc=2
        apb_write(5'h00, 0);
        apb_write(5'h04, 3);
        apb_write(5'h00, 1);
        hr = 0;
        for (int k = 1; k <= 1028; k++) begin
            @(negedge HCLK);
            if (k <= 1024) hr += int'(pwm_out[0]);
            if (k == 1024) begin
                PSEL = 1'b1; PWRITE = 1'b1; PADDR = 5'h04; PWDATA = 0; PENABLE = 1'b0;
            end
            if (k == 1025) PENABLE = 1'b1;
            if (k == 1026) begin PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; end
            if (k == 1028) begin
                PSEL = 1'b1; PADDR = 5'h18;
                #1 check("presc_drop_cnt", PRDATA & 32'hFF, 2);
                PSEL = 1'b0;
            end
        end
        check("presc3_duty", 32'(hr), 256);

        // fade 0 -> 4 with FADE_RATE=1
        apb_write(5'h00, 0);
        apb_write(5'h14, 1);
        apb_write(5'h08, 0);
        apb_write(5'h00, 3);
        for (int m = 0; m < 9; m++) per[m] = 0;
        for (int k = 1; k <= 2304; k++) begin
            @(negedge HCLK);
            per[(k - 1) / 256] += int'(pwm_out[0]);
            if (k == 1) begin
                PSEL = 1'b1; PWRITE = 1'b1; PADDR = 5'h08; PWDATA = 4; PENABLE = 1'b0;
            end
            if (k == 2) PENABLE = 1'b1;
            if (k == 3) begin PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; end
            if (k == 4) check("fade_busy_set", 32'(fade_busy), 1);
            if (k == 2048) begin
                PSEL = 1'b1; PADDR = 5'h18;
                #1 check("fade_status_busy", 32'(PRDATA[8]), 1);
                check("fade_busy_hold", 32'(fade_busy), 1);
            end
            if (k == 2049) begin
                #1 check("fade_status_idle", 32'(PRDATA[8]), 0);
                check("fade_busy_clr", 32'(fade_busy), 0);
                PSEL = 1'b0;
            end
        end
        check("fade_p1", 32'(per[1]), 0);
        check("fade_p2", 32'(per[2]), 1);
        check("fade_p3", 32'(per[3]), 1);
        check("fade_p4", 32'(per[4]), 2);
        check("fade_p6", 32'(per[6]), 3);
        check("fade_p8", 32'(per[8]), 4);

        // disable mid-period, then re-enable
        apb_write(5'h00, 0);
        @(negedge HCLK);
        check("dis_pwm", 32'(pwm_out), 0);
        apb_read(5'h18, rd); check("dis_status", rd, 0);
        apb_write(5'h08, 128);
        apb_write(5'h00, 1);
        PSEL = 1'b1; PADDR = 5'h18;
        #1 check("reen_cnt0", PRDATA, 0);
        PSEL = 1'b0;
        hr = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge HCLK);
            hr += int'(pwm_out[0]);
        end
        check("reen_duty", 32'(hr), 128);
        apb_read(5'h1C, rd); check("unmapped_rd", rd, 0);
        apb_read(5'h00, rd); check("ctrl_rd", rd, 1);
        apb_read(5'h08, rd); check("target_r_rd", rd, 128);
        apb_read(5'h14, rd); check("fade_rate_rd", rd, 1);

        // asynchronous reset mid-period while fading
        apb_write(5'h00, 3);
        apb_write(5'h0C, 10);
        @(negedge HCLK);
        check("pre_rst_busy", 32'(fade_busy), 1);
        #2 HRESETn = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 0);
        check("async_rst_busy", 32'(fade_busy), 0);
        apb_read(5'h00, rd); check("rst2_ctrl", rd, 0);
        apb_read(5'h0C, rd); check("rst2_target_g", rd, 0);
        @(negedge HCLK); HRESETn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
